// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_fifo_pkg
// Description : Shared sizing constants for the RAM-backed FIFO controller
//               and its storage array.
// Contents    : DATA_W    - data width in bits
//               ADDR_W    - RAM address width
//               DEPTH     - RAM entries (2**ADDR_W)
//               BUF_DEPTH - entries in the output skid buffer
// Revision    : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 12;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int BUF_DEPTH = 2;

endpackage : ram_fifo_pkg
`default_nettype wire

// File: rtl/single_clock_wr_ram.sv
`default_nettype none
// ============================================================================
// Module      : single_clock_wr_ram
// Description : Simple dual-port RAM, one clock, registered read port.
//               On a same-cycle read/write to the same address the read
//               returns the data being written (write-first).
//               Contents are not reset.
// Ports       : clk     - clock, rising edge
//               we_i    - write enable
//               waddr_i - write address
//               wdata_i - write data
//               re_i    - read enable; rdata_o updates on the next edge
//               raddr_i - read address
//               rdata_o - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module single_clock_wr_ram #(
  parameter int DATA_W = ram_fifo_pkg::DATA_W,
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int c_words = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [c_words];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      // Write-first collision: forward the incoming word so a read issued
      // in the same cycle as its write sees the new value.
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : single_clock_wr_ram
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : FIFO built from one registered-read RAM used as a circular
//               buffer, followed by a 2-entry output buffer that hides the
//               RAM read latency so one push and one pop can be sustained
//               every cycle. Total capacity is DEPTH + 2 entries.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               flush     - synchronous clear of all stored data
//               in_data   - write data
//               in_valid  - producer has data
//               in_ready  - controller accepts data (!full && !flush)
//               out_data  - head-of-queue data
//               out_valid - out_data holds a valid entry
//               out_ready - consumer takes data
//               level     - total entries held (RAM + in flight + buffer)
//               full      - RAM holds DEPTH entries
//               empty     - level is zero
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATA_W = ram_fifo_pkg::DATA_W,
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  import ram_fifo_pkg::*;

  // RAM occupancy value that means "full" (2**ADDR_W).
  localparam logic [ADDR_W:0] c_full_cnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      c_buf_cap  = 3'(BUF_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q,  ram_cnt_d;
  logic [ADDR_W:0]   level_q,    level_d;
  logic [1:0]        buf_cnt_q,  buf_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf0_q,     buf0_d;     // oldest entry, drives out_data
  logic [DATA_W-1:0] buf1_q,     buf1_d;

  // --------------------------------------------------------------------------
  // Handshakes and read-issue decision
  // --------------------------------------------------------------------------
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_ram_has_data;
  logic [2:0]        w_occ_after;
  logic [DATA_W-1:0] w_rdata;

  assign full      = (ram_cnt_q == c_full_cnt);
  assign in_ready  = !full && !flush;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign level     = level_q;
  assign empty     = (level_q == '0);

  assign w_push = in_valid && in_ready;
  // A pop during flush is dropped along with everything else.
  assign w_pop  = out_valid && out_ready && !flush;

  // Buffer slots committed once this cycle's pop is taken out: entries
  // already buffered plus the word arriving from the RAM next edge.
  // w_pop implies buf_cnt_q > 0, so this never underflows.
  assign w_occ_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};

  // An empty RAM may still be read when a push lands this cycle: rd_ptr
  // then equals wr_ptr and the write-first RAM forwards the new word,
  // giving the two-cycle bypass into the output buffer.
  assign w_ram_has_data = (ram_cnt_q != '0) || w_push;
  assign w_issue        = !flush && w_ram_has_data && (w_occ_after < c_buf_cap);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  single_clock_wr_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .re_i    (w_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_rdata)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    inflight_d = inflight_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    if (flush) begin
      // Counts and pointers clear; any read in flight is simply forgotten.
      // Buffer data is left alone since buf_cnt = 0 hides it.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      buf_cnt_d  = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;   // natural wrap at 2**ADDR_W
      end
      if (w_issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({w_push, w_issue})
        2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
        2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
        default: ram_cnt_d = ram_cnt_q;
      endcase

      inflight_d = w_issue;

      // Pop first (shift entry 1 down), then append the returning RAM word
      // behind whatever remains so ordering is preserved.
      if (w_pop) begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_d - 2'd1;
      end
      if (inflight_q) begin
        if (buf_cnt_d == 2'd0) begin
          buf0_d = w_rdata;
        end else begin
          buf1_d = w_rdata;
        end
        buf_cnt_d = buf_cnt_d + 2'd1;
      end
    end

    level_d = ram_cnt_d
            + {{ADDR_W{1'b0}}, inflight_d}
            + {{(ADDR_W-1){1'b0}}, buf_cnt_d};
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule : ram_fifo_ctrl
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning RAM address width; DEPTH = 2**ADDR_W = 4096.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stored data.
REQ-006 SHALL have port in_data  input  DATA_W  write data.
REQ-007 SHALL have port in_valid  input  1  producer has data.
REQ-008 SHALL have port in_ready  output  1  controller accepts data.
REQ-009 SHALL have port out_data  output  DATA_W  head-of-queue data.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  input  1  consumer takes data.
REQ-012 SHALL have port level  output  ADDR_W+1  total entries held (0..DEPTH+2).
REQ-013 SHALL have port full  output  1  RAM occupancy equals DEPTH.
REQ-014 SHALL have port empty  output  1  level equals 0.

Function
REQ-015 SHALL sequence one RAM (1-cycle registered read, write-first on same-address collision) as a circular FIFO with wr_ptr/rd_ptr of ADDR_W bits, wrapping 4095 -> 0.
REQ-016 SHALL treat a push as in_valid && in_ready; it writes in_data at wr_ptr and increments wr_ptr.
REQ-017 SHALL drive in_ready = !full && !flush, combinationally.
REQ-018 SHALL keep ram_cnt (0..DEPTH): +1 on push, -1 on RAM read issue, unchanged when both occur.
REQ-019 SHALL feed a 2-entry output buffer; a RAM read issues at rd_ptr when (ram_cnt > 0 or push this cycle) and buf_cnt + inflight - pop < 2.
REQ-020 SHALL, when ram_cnt == 0 and a push occurs, issue the read in the same cycle (rd_ptr == wr_ptr) and rely on write-first behaviour for bypass.
REQ-021 SHALL load RAM read data into the output buffer one cycle after issue (inflight flag).
REQ-022 SHALL treat a pop as out_valid && out_ready; out_valid = buf_cnt > 0; out_data = oldest buffer entry.
REQ-023 SHALL give latency push at cycle N -> out_valid at N+2 when empty, and sustain one push and one pop per cycle indefinitely.
REQ-024 SHALL compute level = ram_cnt + inflight + buf_cnt, registered with the pointers.
REQ-025 SHALL, on flush, zero pointers, ram_cnt, buf_cnt and inflight next cycle, discard any in-flight read and ignore push/pop that cycle; flush has priority.
REQ-026 SHALL ignore in_data when in_ready is low; a pop with out_valid low SHALL have no effect.
REQ-027 SHALL preserve strict FIFO order across pointer wrap and the bypass path.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force wr_ptr = rd_ptr = 0, ram_cnt = 0, buf_cnt = 0, inflight = 0, out_data = 0, out_valid = 0, level = 0, empty = 1, full = 0.
REQ-029 SHALL NOT clear RAM contents on reset; stale data is never presented because counts are zeroed.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts, provided flush is low.

Structure
REQ-031 SHALL take DATA_W, ADDR_W, DEPTH and BUF_DEPTH = 2 from shared package ram_fifo_pkg.
REQ-032 SHALL instantiate exactly one sub-module, single_clock_wr_ram, as the storage.
REQ-033 SHALL keep the output buffer and counters inside ram_fifo_ctrl; no further sub-modules.

Verification
REQ-034 Bench SHALL push 0x11 into an empty FIFO with out_ready = 1 -> out_valid high 2 cycles later with out_data = 0x11; level returns to 0.
REQ-035 Bench SHALL push 4098 bytes 0x00..0xFF repeating with out_ready = 0 -> full = 1 after 4098 pushes, in_ready = 0, level = 4098; further in_valid is ignored.
REQ-036 Bench SHALL then drain with out_ready = 1 -> 4098 bytes arrive in order, one per cycle after the first, and empty = 1 at the end.
REQ-037 Bench SHALL run 10000 cycles of simultaneous push/pop with random stalls -> the output sequence equals the input sequence across at least two pointer wraps.
REQ-038 Bench SHALL hold level = 5 with a read in flight, then assert flush for 1 cycle -> next cycle level = 0, out_valid = 0, and the next pushed 0xA5 is the first byte out.
REQ-039 Bench SHALL drop rst_n mid-stream asynchronously -> all outputs take their reset values immediately; after release a push of 0x3C reads back as 0x3C.
